// File: rtl/uart_rx_fifo_if.sv
// Stream bundle between the UART receiver, the receive FIFO and its consumer.
// The master side drives bytes in and accepts them out; the slave side is the FIFO.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH + 1);

    logic [7:0]    rx_data;
    logic          rx_strobe;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          full;
    logic          overflow;
    logic          overflow_clr;
    logic [LW-1:0] lines;
    logic          line_avail;

    modport master (
        output rx_data, rx_strobe, out_ready, overflow_clr,
        input  out_data, out_valid, level, full, overflow, lines, line_avail
    );

    modport slave (
        input  rx_data, rx_strobe, out_ready, overflow_clr,
        output out_data, out_valid, level, full, overflow, lines, line_avail
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: first-word fall-through byte queue
// with fill level, sticky overflow and a count of buffered end-of-line bytes.
module uart_rx_fifo #(
    parameter int         DEPTH = 16,
    parameter logic [7:0] EOL   = 8'h0A
) (
    input logic          clk,
    input logic          rst_n,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [LW-1:0] CNT_ONE = LW'(1);
    localparam logic [LW-1:0] CNT_MAX = LW'(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] lines_r;
    logic          overflow_r;

    logic [7:0]    head_s;
    logic          full_s;
    logic          valid_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic          push_eol_s;
    logic          pop_eol_s;

    // Handshake decode; a pop frees the slot a same-cycle push needs when full
    always_comb begin
        head_s     = mem_r[rd_ptr_r];
        full_s     = (level_r == CNT_MAX);
        valid_s    = (level_r != '0);
        pop_s      = valid_s && bus.out_ready;
        push_s     = bus.rx_strobe && (!full_s || pop_s);
        drop_s     = bus.rx_strobe && full_s && !pop_s;
        push_eol_s = push_s && (bus.rx_data == EOL);
        pop_eol_s  = pop_s && (head_s == EOL);
    end

    // Byte storage, deliberately left unreset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.rx_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Fill level tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + CNT_ONE;
                2'b01:   level_r <= level_r - CNT_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // End-of-line count over bytes currently held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lines_r <= '0;
        end else begin
            case ({push_eol_s, pop_eol_s})
                2'b10:   lines_r <= lines_r + CNT_ONE;
                2'b01:   lines_r <= lines_r - CNT_ONE;
                default: lines_r <= lines_r;
            endcase
        end
    end

    // Sticky overflow; a new drop beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (bus.overflow_clr) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign bus.out_data   = valid_s ? head_s : 8'h00;
    assign bus.out_valid  = valid_s;
    assign bus.level      = level_r;
    assign bus.full       = full_s;
    assign bus.overflow   = overflow_r;
    assign bus.lines      = lines_r;
    assign bus.line_avail = (lines_r != '0);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised plus directed bench for uart_rx_fifo (DEPTH=4, EOL=0A) against a
// queue-based reference model; a negedge monitor compares every output.
module tb_uart_rx_fifo;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .EOL(8'h0A)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: the bytes held, in order, plus the sticky flag
    logic [7:0] model_q[$];
    bit         model_ovf = 1'b0;

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int count_eol();
        int c = 0;
        foreach (model_q[i]) if (model_q[i] == 8'h0A) c++;
        return c;
    endfunction

    // Model update at each clock edge; reset empties it immediately
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            bit do_pop;
            bit do_push;
            do_pop  = (model_q.size() != 0) && bus.out_ready;
            do_push = bus.rx_strobe && ((model_q.size() < DEPTH) || do_pop);
            if (bus.rx_strobe && !do_push) model_ovf = 1'b1;
            else if (bus.overflow_clr) model_ovf = 1'b0;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(bus.rx_data);
        end
    end

    // Monitor: compares every DUT output to the model away from the clock edge
    always @(negedge clk) begin
        int sz;
        sz = model_q.size();
        chk("out_valid",  int'(bus.out_valid),  int'(sz != 0));
        chk("out_data",   int'(bus.out_data),   (sz != 0) ? int'(model_q[0]) : 0);
        chk("level",      int'(bus.level),      sz);
        chk("full",       int'(bus.full),       int'(sz == DEPTH));
        chk("lines",      int'(bus.lines),      count_eol());
        chk("line_avail", int'(bus.line_avail), int'(count_eol() != 0));
        chk("overflow",   int'(bus.overflow),   int'(model_ovf));
    end

    task automatic step(input bit s, input logic [7:0] d, input bit r, input bit c);
        bus.rx_strobe    = s;
        bus.rx_data      = d;
        bus.out_ready    = r;
        bus.overflow_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        bus.rx_strobe    = 1'b0;
        bus.rx_data      = 8'h00;
        bus.out_ready    = 1'b0;
        bus.overflow_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_level", int'(bus.level), 0);
        chk("reset_out_data", int'(bus.out_data), 0);
        rst_n = 1'b1;

        // Single byte through with one-cycle visibility
        step(1'b1, 8'h41, 1'b0, 1'b0);
        chk("first_valid", int'(bus.out_valid), 1);
        chk("first_data", int'(bus.out_data), 8'h41);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("first_popped_data", int'(bus.out_data), 0);
        idle(1);

        // Line counting while full, partial drain
        step(1'b1, 8'h41, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b0, 1'b0);
        step(1'b1, 8'h0A, 1'b0, 1'b0);
        step(1'b1, 8'h43, 1'b0, 1'b0);
        chk("full_lines", int'(bus.lines), 1);
        chk("full_flag", int'(bus.full), 1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("partial_level", int'(bus.level), 1);
        drain();

        // Overflow drop then clear
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        chk("ovf_set", int'(bus.overflow), 1);
        chk("ovf_head", int'(bus.out_data), 8'h11);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", int'(bus.overflow), 0);

        // Push and pop together while full, then drain
        step(1'b1, 8'h66, 1'b1, 1'b0);
        chk("full_pushpop_level", int'(bus.level), DEPTH);
        chk("full_pushpop_ovf", int'(bus.overflow), 0);
        drain();

        // Set beats clear in the same cycle
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h20, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        chk("set_beats_clr", int'(bus.overflow), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        drain();

        // Streaming pairs across pointer wrap
        step(1'b1, 8'h0A, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, (i % 3 == 0) ? 8'h0A : 8'(8'h30 + i), 1'b1, 1'b0);
        drain();

        // Async reset with content and a set overflow flag
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 8'h0A, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_reset_level", int'(bus.level), 3);
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_level", int'(bus.level), 0);
        chk("async_ovf", int'(bus.overflow), 0);
        chk("async_valid", int'(bus.out_valid), 0);
        chk("async_lines", int'(bus.lines), 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic, biased toward EOL bytes and a near-full FIFO
        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            d = ($urandom_range(3) == 0) ? 8'h0A : 8'($urandom);
            step(1'($urandom_range(2) != 0), d, 1'($urandom_range(2) == 0),
                 1'($urandom_range(9) == 0));
        end
        drain();
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
